pipe_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage CPU. It watches register sources in ID, destinations in ID/EX and EX/MEM, and the data-memory handshake in MEM. From these it drives the pipeline-register write enables, bubble insertion, IF flush and a whole-pipe hold. It also runs a memory-wait watchdog with a sticky error flag and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Pipeline hazard/stall controller with memory-wait watchdog and stall counter.
module pipe_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:4]  ID_rA,
  input  logic [0:4]  ID_rB,
  input  logic        ID_useA,
  input  logic        ID_useB,
  input  logic        ID_is_br,
  input  logic        ID_br_ctrl,
  input  logic [0:4]  ID_EX_rD,
  input  logic        ID_EX_wrEn,
  input  logic        ID_EX_load,
  input  logic [0:4]  EX_MEM_rD,
  input  logic        EX_MEM_wrEn,
  input  logic        MEM_memEn,
  input  logic        dmem_ready,
  output logic        PC_wrEn,
  output logic        IF_ID_wrEn,
  output logic        IF_flush,
  output logic        ID_EX_bubble,
  output logic        pipe_hold,
  output logic        mem_err,
  output logic [0:31] stall_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_t;

  state_t         r_state;
  logic [TW-1:0]  r_timer;
  logic           r_mem_err;
  logic [0:31]    r_stall_cnt;

  logic w_memstall;
  logic w_matchA;
  logic w_matchB;
  logic w_loaduse;
  logic w_brhaz;
  logic w_hold;

  always_comb begin
    w_memstall = MEM_memEn & ~dmem_ready;
    w_matchA   = ID_useA & (ID_rA == ID_EX_rD);
    w_matchB   = ID_useB & (ID_rB == ID_EX_rD);
    w_loaduse  = ID_EX_wrEn & ID_EX_load & (w_matchA | w_matchB);
    w_brhaz    = ID_is_br & ID_useB &
                 ((ID_EX_wrEn & (ID_rB == ID_EX_rD)) | (EX_MEM_wrEn & (ID_rB == EX_MEM_rD)));
    case (r_state)
      S_RUN:      w_hold = w_memstall;
      S_MEM_WAIT: w_hold = ~dmem_ready;
      default:    w_hold = 1'b1;
    endcase
  end

  // Whole-pipe hold outranks hazard bubbles, which outrank the branch flush.
  always_comb begin
    PC_wrEn      = 1'b1;
    IF_ID_wrEn   = 1'b1;
    IF_flush     = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (reset) begin
      PC_wrEn      = 1'b0;
      IF_ID_wrEn   = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (w_hold) begin
      PC_wrEn    = 1'b0;
      IF_ID_wrEn = 1'b0;
      pipe_hold  = 1'b1;
    end else if (w_loaduse | w_brhaz) begin
      PC_wrEn      = 1'b0;
      IF_ID_wrEn   = 1'b0;
      ID_EX_bubble = 1'b1;
    end else begin
      IF_flush = ID_is_br & ID_br_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_timer     <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!PC_wrEn && (r_state != S_ERR) && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      case (r_state)
        S_RUN: begin
          if (w_memstall) begin
            r_state <= S_MEM_WAIT;
            r_timer <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= S_RUN;
          end else if (r_timer == TLAST) begin
            r_state   <= S_ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ERR: r_mem_err <= 1'b1;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - Scoreboard testbench for pipe_ctrl with directed hazard/stall vectors.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:4]  ID_rA, ID_rB, ID_EX_rD, EX_MEM_rD;
  logic        ID_useA, ID_useB, ID_is_br, ID_br_ctrl;
  logic        ID_EX_wrEn, ID_EX_load, EX_MEM_wrEn, MEM_memEn, dmem_ready;
  logic        PC_wrEn, IF_ID_wrEn, IF_flush, ID_EX_bubble, pipe_hold, mem_err;
  logic [0:31] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rA(ID_rA), .ID_rB(ID_rB), .ID_useA(ID_useA), .ID_useB(ID_useB),
    .ID_is_br(ID_is_br), .ID_br_ctrl(ID_br_ctrl),
    .ID_EX_rD(ID_EX_rD), .ID_EX_wrEn(ID_EX_wrEn), .ID_EX_load(ID_EX_load),
    .EX_MEM_rD(EX_MEM_rD), .EX_MEM_wrEn(EX_MEM_wrEn),
    .MEM_memEn(MEM_memEn), .dmem_ready(dmem_ready),
    .PC_wrEn(PC_wrEn), .IF_ID_wrEn(IF_ID_wrEn), .IF_flush(IF_flush),
    .ID_EX_bubble(ID_EX_bubble), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       nm;
    logic [5:0]  o;
    bit          chk;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Output vector order: {PC_wrEn, IF_ID_wrEn, IF_flush, ID_EX_bubble, pipe_hold, mem_err}
  localparam logic [5:0] GO   = 6'b110000;
  localparam logic [5:0] FL   = 6'b111000;
  localparam logic [5:0] STL  = 6'b000100;
  localparam logic [5:0] HLD  = 6'b000010;
  localparam logic [5:0] ERRS = 6'b000011;

  initial begin : monitor
    exp_t e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {PC_wrEn, IF_ID_wrEn, IF_flush, ID_EX_bubble, pipe_hold, mem_err};
        checks++;
        if (got !== e.o) begin
          errors++;
          $display("FAIL %s outputs got %b want %b", e.nm, got, e.o);
        end
        if (e.chk) begin
          checks++;
          if (stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s stall_cnt got %h want %h", e.nm, stall_cnt, e.cnt);
          end
        end
      end
    end
  end

  task automatic idle();
    ID_rA = 5'd0; ID_rB = 5'd0; ID_useA = 1'b0; ID_useB = 1'b0;
    ID_is_br = 1'b0; ID_br_ctrl = 1'b0;
    ID_EX_rD = 5'd0; ID_EX_wrEn = 1'b0; ID_EX_load = 1'b0;
    EX_MEM_rD = 5'd0; EX_MEM_wrEn = 1'b0;
    MEM_memEn = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu();
    ID_EX_load = 1'b1; ID_EX_wrEn = 1'b1; ID_EX_rD = 5'd5; ID_rA = 5'd5; ID_useA = 1'b1;
  endtask

  task automatic cyc(input string nm, input logic [5:0] o, input bit chk, input logic [31:0] cnt);
    exp_t e;
    e.nm = nm; e.o = o; e.chk = chk; e.cnt = cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : stim
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc("reset", STL, 1, 0);
    reset = 1'b0;
    cyc("idle", GO, 1, 0);

    set_lu();                                   cyc("loaduse", STL, 1, 0);
    idle();                                     cyc("after_lu", GO, 1, 1);
    set_lu(); ID_useA = 1'b0;                   cyc("lu_nouse", GO, 1, 1);
    idle(); ID_EX_load = 1'b1; ID_EX_wrEn = 1'b1; ID_useB = 1'b1;
                                                cyc("lu_r0_rb", STL, 1, 1);
    idle(); ID_EX_wrEn = 1'b1; ID_EX_rD = 5'd7; ID_rA = 5'd7; ID_useA = 1'b1;
                                                cyc("alu_nostall", GO, 1, 2);
    ID_EX_load = 1'b1; ID_EX_wrEn = 1'b0;       cyc("load_nowr", GO, 1, 2);

    idle(); ID_is_br = 1'b1; ID_useB = 1'b1; ID_rB = 5'd3; ID_br_ctrl = 1'b1;
    ID_EX_rD = 5'd3; ID_EX_wrEn = 1'b1;         cyc("brhaz_ex", STL, 1, 2);
    ID_EX_wrEn = 1'b0; EX_MEM_rD = 5'd3; EX_MEM_wrEn = 1'b1;
                                                cyc("brhaz_mem", STL, 1, 3);
    EX_MEM_wrEn = 1'b0;                         cyc("br_taken", FL, 1, 4);
    idle();                                     cyc("after_br", GO, 1, 4);
    ID_is_br = 1'b1;                            cyc("br_nottaken", GO, 0, 0);

    idle(); MEM_memEn = 1'b1;                   cyc("memwait0", HLD, 1, 4);
    ID_is_br = 1'b1; ID_br_ctrl = 1'b1;         cyc("memwait1_br", HLD, 1, 5);
    ID_is_br = 1'b0; ID_br_ctrl = 1'b0;         cyc("memwait2", HLD, 1, 6);
    dmem_ready = 1'b1;                          cyc("mem_ready", GO, 1, 7);
    idle();                                     cyc("after_mem", GO, 1, 7);

    MEM_memEn = 1'b1; set_lu();                 cyc("prio_hold", HLD, 1, 7);
    dmem_ready = 1'b1;                          cyc("prio_lu", STL, 1, 8);
    idle();                                     cyc("after_prio", GO, 1, 9);

    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cnt;
    set_lu();                                   cyc("sat0", STL, 1, 32'hFFFF_FFFD);
                                                cyc("sat1", STL, 1, 32'hFFFF_FFFE);
                                                cyc("sat2", STL, 1, 32'hFFFF_FFFF);
    idle();                                     cyc("sat3", GO, 1, 32'hFFFF_FFFF);

    MEM_memEn = 1'b1;                           cyc("midw0", HLD, 1, 32'hFFFF_FFFF);
                                                cyc("midw1", HLD, 1, 32'hFFFF_FFFF);
    reset = 1'b1;                               cyc("midw_rst", STL, 1, 32'hFFFF_FFFF);
    reset = 1'b0; idle();                       cyc("midw_after", GO, 1, 0);

    MEM_memEn = 1'b1;
    for (int i = 0; i < 5; i++)                 cyc($sformatf("wd%0d", i), HLD, 1, i);
                                                cyc("wd_err", ERRS, 1, 5);
    dmem_ready = 1'b1; set_lu();                cyc("wd_stuck", ERRS, 1, 5);
                                                cyc("wd_stuck2", ERRS, 1, 5);
    reset = 1'b1; idle();
    @(negedge clk);
    reset = 1'b0;                               cyc("wd_recover", GO, 1, 0);
    MEM_memEn = 1'b1; dmem_ready = 1'b1;        cyc("mem_fast", GO, 1, 0);
    idle();
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
